// File: rtl/counter_ctrl_pkg.sv
// Shared types and constants for the counter_ctrl sequencer and its bench.
package counter_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    PAUSE = 2'b10,
    DONE  = 2'b11
  } state_e;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_RELOAD  = 1'b1;

  function automatic logic is_busy(input state_e s);
    return (s == RUN) || (s == PAUSE);
  endfunction

endpackage

// File: rtl/counter_ctrl_sync_counter.sv
// Fully synchronous up-counter with clear priority over enable; no ripple stages.
module sync_counter #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] q_d;

  // next count value
  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (en) begin
      q_d = q_q + WIDTH'(1'b1);
    end else begin
      q_d = q_q;
    end
  end

  // count register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q = q_q;

endmodule

// File: rtl/counter_ctrl.sv
// Start/pause/stop/reload sequencer driving a prescaled synchronous counter
// with a registered one-cycle terminal-count pulse.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int PRE_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stop,
  input  logic             pause,
  input  logic             mode,
  input  logic [WIDTH-1:0] term,
  input  logic [PRE_W-1:0] prescale,
  output logic [WIDTH-1:0] cnt,
  output logic             busy,
  output logic             tc,
  output logic             done,
  output logic [1:0]       state
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] term_l_q, term_l_d;
  logic             mode_l_q, mode_l_d;
  logic [PRE_W-1:0] pre_l_q, pre_l_d;
  logic [PRE_W-1:0] pcnt_q, pcnt_d;
  logic             tc_q, tc_d;
  logic             cnt_clr_s;
  logic             cnt_en_s;
  logic [WIDTH-1:0] cnt_s;

  sync_counter #(.WIDTH(WIDTH)) u_cnt (
    .clk (clk),
    .rst (rst),
    .clr (cnt_clr_s),
    .en  (cnt_en_s),
    .q   (cnt_s)
  );

  // next-state, prescaler and terminal-count decision (stop > pause > tick)
  always_comb begin
    state_d   = state_q;
    term_l_d  = term_l_q;
    mode_l_d  = mode_l_q;
    pre_l_d   = pre_l_q;
    pcnt_d    = pcnt_q;
    tc_d      = 1'b0;
    cnt_clr_s = 1'b0;
    cnt_en_s  = 1'b0;
    if (stop) begin
      state_d   = IDLE;
      pcnt_d    = '0;
      cnt_clr_s = 1'b1;
    end else begin
      case (state_q)
        IDLE, DONE: begin
          if (start) begin
            term_l_d  = term;
            mode_l_d  = mode;
            pre_l_d   = prescale;
            pcnt_d    = '0;
            cnt_clr_s = 1'b1;
            state_d   = RUN;
          end else begin
            state_d = state_q;
          end
        end
        RUN, PAUSE: begin
          // leaving PAUSE processes a tick in the same cycle, so a pause costs exactly its length
          if (pause) begin
            state_d = PAUSE;
          end else begin
            state_d = RUN;
            if (pcnt_q == pre_l_q) begin
              pcnt_d = '0;
              if (cnt_s == term_l_q) begin
                tc_d = 1'b1;
                if (mode_l_q == MODE_RELOAD) begin
                  cnt_clr_s = 1'b1;
                end else begin
                  state_d = DONE;
                end
              end else begin
                cnt_en_s = 1'b1;
              end
            end else begin
              pcnt_d = pcnt_q + PRE_W'(1'b1);
            end
          end
        end
        default: begin
          state_d   = IDLE;
          pcnt_d    = '0;
          cnt_clr_s = 1'b1;
        end
      endcase
    end
  end

  // FSM, latches, prescaler and tc registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      term_l_q <= '0;
      mode_l_q <= MODE_ONESHOT;
      pre_l_q  <= '0;
      pcnt_q   <= '0;
      tc_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      term_l_q <= term_l_d;
      mode_l_q <= mode_l_d;
      pre_l_q  <= pre_l_d;
      pcnt_q   <= pcnt_d;
      tc_q     <= tc_d;
    end
  end

  assign cnt   = cnt_s;
  assign tc    = tc_q;
  assign busy  = is_busy(state_q);
  assign done  = (state_q == DONE);
  assign state = state_q;

endmodule

// File: tb/tb_counter_ctrl.sv
// Directed self-checking bench for counter_ctrl; each task checks one feature.
module tb_counter_ctrl;
  import counter_ctrl_pkg::*;

  logic       clk;
  logic       rst;
  logic       start;
  logic       stop;
  logic       pause;
  logic       mode;
  logic [3:0] term;
  logic [3:0] prescale;
  logic [3:0] cnt;
  logic       busy;
  logic       tc;
  logic       done;
  logic [1:0] state;

  int n_checks;
  int n_fail;

  // observed bundle: {state, busy, tc, done, cnt}
  logic [8:0] obs;
  logic [8:0] exp_v;
  assign obs = {state, busy, tc, done, cnt};

  counter_ctrl #(.WIDTH(4), .PRE_W(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .pause    (pause),
    .mode     (mode),
    .term     (term),
    .prescale (prescale),
    .cnt      (cnt),
    .busy     (busy),
    .tc       (tc),
    .done     (done),
    .state    (state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [3:0] t, input logic [3:0] p, input logic m);
    term = t; prescale = p; mode = m; start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    #2;
    exp_v = {IDLE, 1'b0, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL reset_hold: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    @(negedge clk);
    rst = 1'b1;
    step();
    if (obs !== exp_v) begin $display("FAIL reset_release: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
  endtask

  task automatic test_oneshot(input string tag);
    do_start(4'd3, 4'd0, MODE_ONESHOT);
    exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL %s_start: got %h expected %h", tag, obs, exp_v); n_fail++; end
    n_checks++;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'(i)};
      if (obs !== exp_v) begin $display("FAIL %s_count%0d: got %h expected %h", tag, i, obs, exp_v); n_fail++; end
      n_checks++;
    end
    step();
    exp_v = {DONE, 1'b0, 1'b1, 1'b1, 4'd3};
    if (obs !== exp_v) begin $display("FAIL %s_terminal: got %h expected %h", tag, obs, exp_v); n_fail++; end
    n_checks++;
    step();
    exp_v = {DONE, 1'b0, 1'b0, 1'b1, 4'd3};
    if (obs !== exp_v) begin $display("FAIL %s_done_hold: got %h expected %h", tag, obs, exp_v); n_fail++; end
    n_checks++;
  endtask

  task automatic test_reload_prescale();
    do_start(4'd2, 4'd1, MODE_RELOAD);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_v = {RUN, 1'b1, ((k % 6) == 0), 1'b0, 4'((k / 2) % 3)};
      if (obs !== exp_v) begin $display("FAIL reload_edge%0d: got %h expected %h", k, obs, exp_v); n_fail++; end
      n_checks++;
    end
    stop = 1'b1;
    step();
    stop = 1'b0;
    exp_v = {IDLE, 1'b0, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL reload_stop: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
  endtask

  task automatic test_boundaries();
    do_start(4'd15, 4'd0, MODE_RELOAD);
    for (int k = 1; k <= 17; k++) begin
      step();
      exp_v = {RUN, 1'b1, (k == 16), 1'b0, 4'(k % 16)};
      if (obs !== exp_v) begin $display("FAIL term15_edge%0d: got %h expected %h", k, obs, exp_v); n_fail++; end
      n_checks++;
    end
    stop = 1'b1; step(); stop = 1'b0;
    do_start(4'd0, 4'd0, MODE_RELOAD);
    exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL term0_start: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    for (int k = 1; k <= 4; k++) begin
      step();
      exp_v = {RUN, 1'b1, 1'b1, 1'b0, 4'd0};
      if (obs !== exp_v) begin $display("FAIL term0_edge%0d: got %h expected %h", k, obs, exp_v); n_fail++; end
      n_checks++;
    end
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_pause_stop();
    do_start(4'd9, 4'd0, MODE_ONESHOT);
    repeat (5) step();
    exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'd5};
    if (obs !== exp_v) begin $display("FAIL pause_pre: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    pause = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      step();
      exp_v = {PAUSE, 1'b1, 1'b0, 1'b0, 4'd5};
      if (obs !== exp_v) begin $display("FAIL pause_hold%0d: got %h expected %h", i, obs, exp_v); n_fail++; end
      n_checks++;
    end
    pause = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      step();
      exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'(5 + i)};
      if (obs !== exp_v) begin $display("FAIL pause_resume%0d: got %h expected %h", i, obs, exp_v); n_fail++; end
      n_checks++;
    end
    step();
    exp_v = {DONE, 1'b0, 1'b1, 1'b1, 4'd9};
    if (obs !== exp_v) begin $display("FAIL pause_terminal: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;

    // stop lands on the edge that would have been terminal
    do_start(4'd7, 4'd0, MODE_RELOAD);
    repeat (7) step();
    exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'd7};
    if (obs !== exp_v) begin $display("FAIL stop_pre: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    stop = 1'b1;
    step();
    stop = 1'b0;
    exp_v = {IDLE, 1'b0, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL stop_abort: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    step();
    if (obs !== exp_v) begin $display("FAIL stop_no_tc: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    start = 1'b1; stop = 1'b1;
    step();
    start = 1'b0; stop = 1'b0;
    if (obs !== exp_v) begin $display("FAIL start_stop: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
  endtask

  task automatic test_restart();
    do_start(4'd2, 4'd0, MODE_ONESHOT);
    repeat (4) step();
    exp_v = {DONE, 1'b0, 1'b0, 1'b1, 4'd2};
    if (obs !== exp_v) begin $display("FAIL restart_done: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    do_start(4'd5, 4'd0, MODE_RELOAD);
    exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL restart_start: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    repeat (2) step();
    term = 4'd1; mode = MODE_ONESHOT; start = 1'b1;
    step();
    start = 1'b0;
    exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'd3};
    if (obs !== exp_v) begin $display("FAIL start_ignored: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    repeat (3) step();
    exp_v = {RUN, 1'b1, 1'b1, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL restart_reload: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    stop = 1'b1; step(); stop = 1'b0;
  endtask

  task automatic test_async_reset();
    do_start(4'd9, 4'd0, MODE_ONESHOT);
    repeat (3) step();
    exp_v = {RUN, 1'b1, 1'b0, 1'b0, 4'd3};
    if (obs !== exp_v) begin $display("FAIL areset_pre: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    #3;
    rst = 1'b0;
    #1;
    exp_v = {IDLE, 1'b0, 1'b0, 1'b0, 4'd0};
    if (obs !== exp_v) begin $display("FAIL areset_immediate: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    repeat (2) step();
    if (obs !== exp_v) begin $display("FAIL areset_held: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    @(negedge clk);
    rst = 1'b1;
    step();
    if (obs !== exp_v) begin $display("FAIL areset_release: got %h expected %h", obs, exp_v); n_fail++; end
    n_checks++;
    test_oneshot("post_reset");
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
    mode = 1'b0; term = 4'd0; prescale = 4'd0;
    test_reset();
    test_oneshot("oneshot");
    test_reload_prescale();
    test_boundaries();
    test_pause_stop();
    test_restart();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Programmable sequencer for the 4-bit up-counter datapath: it starts, pauses, stops and reloads a synchronous counter. The counter advances at a prescaled rate and signals a terminal count at a programmed value. The block sits between a host control interface and every consumer of the count value and terminal-count event. It runs in one-shot or auto-reload mode.

## Interface

Parameters:
- WIDTH, 4, counter width; terminal value range 0..2^WIDTH-1
- PRE_W, 4, prescaler width

Ports:
- clk  in  1  clock; all state changes on posedge
- rst  in  1  reset, asynchronous, active-low (0 = reset)
- start  in  1  start request, sampled on posedge
- stop  in  1  stop request, sampled on posedge
- pause  in  1  level; freezes the count while high
- mode  in  1  0 = one-shot, 1 = auto-reload; latched at start
- term  in  WIDTH  terminal count value; latched at start
- prescale  in  PRE_W  count advances every prescale+1 clocks; latched at start
- cnt  out  WIDTH  current count
- busy  out  1  high in RUN or PAUSE
- tc  out  1  one-cycle pulse at terminal count
- done  out  1  level, high in DONE
- state  out  2  current FSM state

## Operation

- States: IDLE, RUN, PAUSE, DONE.
- Latched registers: term_l, mode_l, pre_l. Internal prescaler: pcnt.
- IDLE or DONE, start=1: latch term, mode and prescale; cnt<=0, pcnt<=0, go to RUN.
- start is ignored in RUN and PAUSE.
- Priority each cycle: stop > pause > tick.
- stop=1 in any state: go to IDLE; cnt<=0, pcnt<=0, tc<=0.
- start=1 and stop=1 in the same cycle: stop wins, end state is IDLE.
- RUN, pause=1: go to PAUSE. No tick is processed that cycle; cnt and pcnt hold.
- PAUSE, pause=0: go to RUN; resume from the held cnt and pcnt.
- RUN, no pause: if pcnt==pre_l then pcnt<=0 and a tick occurs; otherwise pcnt<=pcnt+1.
- Tick with cnt!=term_l: cnt<=cnt+1.
- Tick with cnt==term_l:
  - tc<=1 for exactly one cycle.
  - mode_l=1: cnt<=0, stay in RUN.
  - mode_l=0: cnt holds term_l, go to DONE.
- term=0: every tick is a terminal tick.
- term=2^WIDTH-1: the terminal is reached at all-ones and the count wraps to 0 only by reload. cnt never overflows.
- DONE: cnt holds term_l, done=1 until start or stop.
- Outputs busy, done and state decode directly from the state register.

## Timing

- Reset asserted (rst=0): immediately state=IDLE, cnt=0, busy=0, tc=0, done=0, pcnt=0, all latches 0.
- Reset is held through the rising edge of rst. First active edge is the first posedge after rst=1.
- Reset mid-RUN aborts with no tc.
- Start latency: after the posedge that samples start, state=RUN, busy=1, cnt=0.
- With prescale=p, cnt increments on every (p+1)th posedge in RUN.
- Terminal tick occurs (term_l+1)*(p+1) edges after the start edge.
- tc is registered and is high in the cycle following the terminal edge.
- In one-shot mode, done and tc rise on the same edge; tc drops one edge later.
- Auto-reload period is (term_l+1)*(p+1) clocks. tc pulses are spaced exactly by that period when there is no pause.
- Pause adds exactly its duration in cycles to the period. A pause of one cycle costs one cycle.

## Structure

- Package counter_ctrl_pkg:
  - typedef enum logic [1:0] state_e: IDLE=2'b00, RUN=2'b01, PAUSE=2'b10, DONE=2'b11
  - constants MODE_ONESHOT=1'b0, MODE_RELOAD=1'b1
- Sub-module sync_counter:
  - parameter WIDTH; ports clk, rst, clr, en, q
  - fully synchronous counter with a single clock domain, replacing any ripple chain so cnt is glitch-free
- FSM, prescaler and latches live in counter_ctrl.

## Test plan

- Reset and one-shot: reset, then start with term=3, prescale=0, mode=0 -> cnt steps 0,1,2,3 on consecutive edges. tc and done go high 4 edges after start; tc lasts 1 cycle; cnt stays 3; busy=0.
- Auto-reload with prescale: term=2, prescale=1, mode=1 -> cnt changes every 2 clocks, sequence 0,1,2,0,1,2. tc pulses every 6 clocks; state stays RUN.
- Boundaries: term=15 with mode=1 -> cnt reaches 15 then 0, with tc at the 15->0 transition. term=0 with prescale=0 -> tc every cycle after the first, cnt stays 0.
- Pause and stop: pause for 3 cycles at cnt=5 -> cnt holds 5, state=PAUSE, terminal delayed by exactly 3 cycles. Stop at cnt=7 -> IDLE, cnt=0, no tc. Simultaneous start+stop -> IDLE.
- Start ignored and restart: start pulses in RUN have no effect. Start in DONE relatches new term and mode and restarts from 0.
- Async reset mid-RUN: drop rst between edges -> outputs clear without waiting for a clock edge; no tc afterward; first start after release behaves like the one-shot case.
